// File: rtl/complex_div.sv
// Sequential fixed-point complex divider (a1 + j*b1) / (a2 + j*b2).
// A single multiply stage forms the conjugate numerators and |divisor|^2; two restoring dividers then share that denominator.
module complex_div #(
    parameter int  DATA_LEN = 8,
    parameter int  FRAC_LEN = 8,
    localparam int QBITS    = 2 * DATA_LEN + FRAC_LEN,
    localparam int OUT_LEN  = QBITS + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_LEN-1:0] a1,
    input  logic signed [DATA_LEN-1:0] b1,
    input  logic signed [DATA_LEN-1:0] a2,
    input  logic signed [DATA_LEN-1:0] b2,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic signed [OUT_LEN-1:0]  q_re,
    output logic signed [OUT_LEN-1:0]  q_im,
    output logic                       div_by_zero,
    output logic                       out_vld,
    input  logic                       out_rdy
);

    localparam int MUL_W = 2 * DATA_LEN + 1;
    localparam int DEN_W = 2 * DATA_LEN;
    localparam int CNT_W = $clog2(QBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic signed [DATA_LEN-1:0]  a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
    logic [DEN_W-1:0]            den_q, den_d;
    logic                        sgn_re_q, sgn_re_d, sgn_im_q, sgn_im_d;
    // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
    logic [QBITS-1:0]            dvd_re_q, dvd_re_d, dvd_im_q, dvd_im_d;
    logic [DEN_W-1:0]            rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [OUT_LEN-1:0]   q_re_q, q_re_d, q_im_q, q_im_d;
    logic                        dbz_q, dbz_d;

    logic signed [MUL_W-1:0]     num_re_s, num_im_s;
    logic [DEN_W-1:0]            den_s, mag_re_s, mag_im_s;
    logic [DEN_W:0]              step_re_s, step_im_s;
    logic [OUT_LEN-1:0]          qmag_re_s, qmag_im_s;

    // One restoring step: returns {new remainder, quotient bit}.
    function automatic logic [DEN_W:0] div_step(input logic [DEN_W-1:0] rem,
                                                input logic             dbit,
                                                input logic [DEN_W-1:0] den);
        logic [DEN_W:0] trial;
        logic [DEN_W:0] diff;
        trial = {rem, dbit};
        diff  = trial - {1'b0, den};
        if (trial >= {1'b0, den}) begin
            div_step = {diff[DEN_W-1:0], 1'b1};
        end else begin
            div_step = {trial[DEN_W-1:0], 1'b0};
        end
    endfunction

    assign num_re_s  = MUL_W'(a1_q) * MUL_W'(a2_q) + MUL_W'(b1_q) * MUL_W'(b2_q);
    assign num_im_s  = MUL_W'(b1_q) * MUL_W'(a2_q) - MUL_W'(a1_q) * MUL_W'(b2_q);
    assign den_s     = DEN_W'(MUL_W'(a2_q) * MUL_W'(a2_q) + MUL_W'(b2_q) * MUL_W'(b2_q));
    assign mag_re_s  = DEN_W'(num_re_s[MUL_W-1] ? -num_re_s : num_re_s);
    assign mag_im_s  = DEN_W'(num_im_s[MUL_W-1] ? -num_im_s : num_im_s);
    assign step_re_s = div_step(rem_re_q, dvd_re_q[QBITS-1], den_q);
    assign step_im_s = div_step(rem_im_q, dvd_im_q[QBITS-1], den_q);
    assign qmag_re_s = {1'b0, dvd_re_q[QBITS-2:0], step_re_s[0]};
    assign qmag_im_s = {1'b0, dvd_im_q[QBITS-2:0], step_im_s[0]};

    assign in_rdy      = (state_q == S_IDLE);
    assign out_vld     = (state_q == S_DONE);
    assign q_re        = q_re_q;
    assign q_im        = q_im_q;
    assign div_by_zero = dbz_q;

    // Next-state and datapath update for the accept/multiply/divide/hold sequence.
    always_comb begin
        state_d  = state_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        a2_d     = a2_q;
        b2_d     = b2_q;
        den_d    = den_q;
        sgn_re_d = sgn_re_q;
        sgn_im_d = sgn_im_q;
        dvd_re_d = dvd_re_q;
        dvd_im_d = dvd_im_q;
        rem_re_d = rem_re_q;
        rem_im_d = rem_im_q;
        cnt_d    = cnt_q;
        q_re_d   = q_re_q;
        q_im_d   = q_im_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_vld) begin
                    a1_d    = a1;
                    b1_d    = b1;
                    a2_d    = a2;
                    b2_d    = b2;
                    dbz_d   = 1'b0;
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                den_d    = den_s;
                sgn_re_d = num_re_s[MUL_W-1];
                sgn_im_d = num_im_s[MUL_W-1];
                dvd_re_d = {mag_re_s, {FRAC_LEN{1'b0}}};
                dvd_im_d = {mag_im_s, {FRAC_LEN{1'b0}}};
                rem_re_d = {DEN_W{1'b0}};
                rem_im_d = {DEN_W{1'b0}};
                cnt_d    = {CNT_W{1'b0}};
                if (den_s == {DEN_W{1'b0}}) begin
                    dbz_d   = 1'b1;
                    q_re_d  = {OUT_LEN{1'b0}};
                    q_im_d  = {OUT_LEN{1'b0}};
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_re_d = step_re_s[DEN_W:1];
                rem_im_d = step_im_s[DEN_W:1];
                dvd_re_d = {dvd_re_q[QBITS-2:0], step_re_s[0]};
                dvd_im_d = {dvd_im_q[QBITS-2:0], step_im_s[0]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    q_re_d  = sgn_re_q ? -qmag_re_s : qmag_re_s;
                    q_im_d  = sgn_im_q ? -qmag_im_s : qmag_im_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a1_q     <= {DATA_LEN{1'b0}};
            b1_q     <= {DATA_LEN{1'b0}};
            a2_q     <= {DATA_LEN{1'b0}};
            b2_q     <= {DATA_LEN{1'b0}};
            den_q    <= {DEN_W{1'b0}};
            sgn_re_q <= 1'b0;
            sgn_im_q <= 1'b0;
            dvd_re_q <= {QBITS{1'b0}};
            dvd_im_q <= {QBITS{1'b0}};
            rem_re_q <= {DEN_W{1'b0}};
            rem_im_q <= {DEN_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            q_re_q   <= {OUT_LEN{1'b0}};
            q_im_q   <= {OUT_LEN{1'b0}};
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            a2_q     <= a2_d;
            b2_q     <= b2_d;
            den_q    <= den_d;
            sgn_re_q <= sgn_re_d;
            sgn_im_q <= sgn_im_d;
            dvd_re_q <= dvd_re_d;
            dvd_im_q <= dvd_im_d;
            rem_re_q <= rem_re_d;
            rem_im_q <= rem_im_d;
            cnt_q    <= cnt_d;
            q_re_q   <= q_re_d;
            q_im_q   <= q_im_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: tb/tb_complex_div.sv
// Bench for complex_div: directed plan cases plus a randomized stream against an integer-arithmetic model.
module tb_complex_div;

    localparam int DATA_LEN = 8;
    localparam int FRAC_LEN = 8;
    localparam int OUT_LEN  = 2 * DATA_LEN + FRAC_LEN + 1;
    localparam int LAT      = 2 * DATA_LEN + FRAC_LEN + 1;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic signed [DATA_LEN-1:0] a1 = 8'sd0, b1 = 8'sd0, a2 = 8'sd0, b2 = 8'sd0;
    logic                       in_vld = 1'b0;
    logic                       in_rdy;
    logic signed [OUT_LEN-1:0]  q_re, q_im;
    logic                       div_by_zero;
    logic                       out_vld;
    logic                       out_rdy = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int a1; int b1; int a2; int b2; } op_t;
    op_t pend[$];

    complex_div #(.DATA_LEN(DATA_LEN), .FRAC_LEN(FRAC_LEN)) dut (
        .clk(clk), .rst(rst), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
        .in_vld(in_vld), .in_rdy(in_rdy), .q_re(q_re), .q_im(q_im),
        .div_by_zero(div_by_zero), .out_vld(out_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: exact complex division scaled by 2^FRAC_LEN, C-style truncation toward zero.
    function automatic void model(input int xa1, input int xb1, input int xa2, input int xb2,
                                  output int qr, output int qi, output int dz);
        int nr, ni, den;
        nr  = xa1 * xa2 + xb1 * xb2;
        ni  = xb1 * xa2 - xa1 * xb2;
        den = xa2 * xa2 + xb2 * xb2;
        if (den == 0) begin
            qr = 0; qi = 0; dz = 1;
        end else begin
            qr = (nr * (1 << FRAC_LEN)) / den;
            qi = (ni * (1 << FRAC_LEN)) / den;
            dz = 0;
        end
    endfunction

    task automatic wait_vld(output int cyc);
        cyc = 0;
        while (out_vld !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic scramble();
        a1 = 8'($urandom); b1 = 8'($urandom); a2 = 8'($urandom); b2 = 8'($urandom);
    endtask

    // One full operation with out_rdy high: accept, latency, result, handshake.
    task automatic do_op(input string tag, input int xa1, input int xb1, input int xa2, input int xb2);
        int qr, qi, dz, cyc;
        model(xa1, xb1, xa2, xb2, qr, qi, dz);
        a1 = 8'(xa1); b1 = 8'(xb1); a2 = 8'(xa2); b2 = 8'(xb2);
        in_vld = 1'b1;
        chk({tag, "_in_rdy"}, in_rdy, 1);
        tick();
        in_vld = 1'b0;
        scramble();
        wait_vld(cyc);
        chk({tag, "_latency"}, cyc, (dz != 0) ? 1 : LAT);
        chk({tag, "_q_re"}, q_re, qr);
        chk({tag, "_q_im"}, q_im, qi);
        chk({tag, "_dbz"}, div_by_zero, dz);
        tick();
        chk({tag, "_vld_drop"}, out_vld, 0);
        chk({tag, "_rdy_back"}, in_rdy, 1);
    endtask

    initial begin
        int qr, qi, dz, cyc, last_acc, vld_seen;
        logic was_rdy;
        op_t o;

        #3;
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_q_re", q_re, 0);
        chk("rst_q_im", q_im, 0);
        chk("rst_dbz", div_by_zero, 0);
        tick();
        rst = 1'b0;
        tick();

        do_op("t1", 3, 4, 1, 2);
        chk("t1_const_re", q_re, 563);
        chk("t1_const_im", q_im, -102);
        do_op("t2a", -128, -128, -128, 0);
        chk("t2a_const_re", q_re, 256);
        do_op("t2b", -128, -128, 1, 0);
        chk("t2b_const_im", q_im, -32768);
        do_op("t3a", 5, 7, 0, 0);
        do_op("t3b", 2, 0, 1, 0);
        chk("t3b_const_re", q_re, 512);

        // Backpressure: result must hold while out_rdy is low.
        model(7, -3, 2, 5, qr, qi, dz);
        out_rdy = 1'b0;
        a1 = 8'sd7; b1 = -8'sd3; a2 = 8'sd2; b2 = 8'sd5;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        wait_vld(cyc);
        chk("bp_latency", cyc, LAT);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", out_vld, 1);
            chk("bp_q_re", q_re, qr);
            chk("bp_q_im", q_im, qi);
            chk("bp_in_rdy", in_rdy, 0);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        chk("bp_release", out_vld, 0);
        tick();
        chk("bp_single", out_vld, 0);
        chk("bp_idle", in_rdy, 1);

        // Continuous in_vld with operands changing every cycle.
        last_acc = -1;
        for (int c = 0; c < 150; c++) begin
            scramble();
            if (a2 == 8'sd0 && b2 == 8'sd0) a2 = 8'sd1;
            in_vld  = 1'b1;
            was_rdy = in_rdy;
            o.a1 = int'(a1); o.b1 = int'(b1); o.a2 = int'(a2); o.b2 = int'(b2);
            tick();
            if (was_rdy) begin
                pend.push_back(o);
                if (last_acc >= 0) chk("st_spacing", c - last_acc, LAT + 2);
                last_acc = c;
            end
            if (out_vld === 1'b1) begin
                chk("st_pending", pend.size() > 0, 1);
                if (pend.size() > 0) begin
                    o = pend.pop_front();
                    model(o.a1, o.b1, o.a2, o.b2, qr, qi, dz);
                    chk("st_q_re", q_re, qr);
                    chk("st_q_im", q_im, qi);
                    chk("st_dbz", div_by_zero, dz);
                end
            end
        end
        in_vld = 1'b0;
        wait_vld(cyc);
        chk("st_drain_vld", out_vld, 1);
        if (pend.size() > 0) begin
            o = pend.pop_front();
            model(o.a1, o.b1, o.a2, o.b2, qr, qi, dz);
            chk("st_drain_re", q_re, qr);
            chk("st_drain_im", q_im, qi);
        end
        tick();
        chk("st_empty", pend.size(), 0);

        // Reset during DIV iteration 10.
        do_op("pre_rst", 100, -20, 3, 4);
        a1 = -8'sd50; b1 = 8'sd33; a2 = -8'sd7; b2 = 8'sd12;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        repeat (11) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_vld", out_vld, 0);
        chk("ar_q_re", q_re, 0);
        chk("ar_q_im", q_im, 0);
        chk("ar_dbz", div_by_zero, 0);
        chk("ar_in_rdy", in_rdy, 1);
        repeat (2) tick();
        rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_vld !== 1'b0) vld_seen++;
        end
        chk("ar_no_stale", vld_seen, 0);
        do_op("post_rst", -50, 33, -7, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/complex_div.md
Name: complex_div

Overview:
- Sequential fixed-point complex divider: (a1 + j·b1) / (a2 + j·b2). Inverse operation of the team's pipelined complex multiplier.
- Sits in the same DSP datapath, downstream of the multiplier, where equalisation or normalisation needs division.
- Computes the conjugate-product numerators and the squared-magnitude denominator in one multiply stage.
- Then runs two parallel restoring dividers (real, imaginary) that share that denominator.
- Valid/ready handshake on input and output; one operation in flight.

Parameters:
- DATA_LEN, 8, width of each signed input component.
- FRAC_LEN, 8, number of fractional bits in each output component.
- QBITS (localparam), 2*DATA_LEN+FRAC_LEN, quotient magnitude bits; equals division iteration count.
- OUT_LEN (localparam), QBITS+1, signed output component width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a1  in  DATA_LEN  dividend real, signed
- b1  in  DATA_LEN  dividend imaginary, signed
- a2  in  DATA_LEN  divisor real, signed
- b2  in  DATA_LEN  divisor imaginary, signed
- in_vld  in  1  input operands valid
- in_rdy  out  1  block can accept operands
- q_re  out  OUT_LEN  quotient real, signed, FRAC_LEN fractional bits
- q_im  out  OUT_LEN  quotient imaginary, signed, FRAC_LEN fractional bits
- div_by_zero  out  1  current result had a2 = b2 = 0
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts result

Behaviour:
- Reset values: state IDLE, in_rdy=1, out_vld=0, q_re=0, q_im=0, div_by_zero=0; counter and internal registers cleared.
- Reset mid-operation: the operation is discarded immediately and no out_vld is produced for it.
- FSM states: IDLE, MUL, DIV, DONE.
- in_rdy = (state == IDLE). Accept occurs on an edge where in_vld & in_rdy; operands are registered at that edge and the FSM goes to MUL.
- MUL (1 cycle), computes:
  - num_re = a1·a2 + b1·b2
  - num_im = b1·a2 − a1·b2
  - den = a2² + b2²
- MUL arithmetic: full-precision signed, 2*DATA_LEN+1 bits; den is unsigned, 2*DATA_LEN bits.
- MUL registers the sign of each numerator and its magnitude.
- MUL → DONE if den == 0: set div_by_zero=1, q_re=q_im=0.
- MUL → DIV otherwise: counter=0, each dividend magnitude = |num| << FRAC_LEN.
- DIV: one restoring step per cycle for both components. MSB-first, QBITS iterations, shared den.
- After the last iteration the FSM goes to DONE. Each quotient magnitude is negated if its numerator sign was negative.
- Rounding: truncation toward zero. The remainder is discarded.
- Overflow: none possible. |num| ≤ 2^(2*DATA_LEN−1) and den ≥ 1, so the result fits OUT_LEN.
- Latency, accept edge to the edge that raises out_vld:
  - Normal: QBITS+1 cycles (25 at defaults).
  - div_by_zero: 1 cycle.
- DONE: out_vld=1. q_re, q_im and div_by_zero are held stable while out_vld & !out_rdy.
- DONE exit: on out_vld & out_rdy, go to IDLE; out_vld=0 next cycle. Outputs keep their last values, and div_by_zero clears at the next accept.
- No accept is possible in DONE. Minimum spacing between accepts is QBITS+3 cycles.
- in_vld while busy is ignored; the upstream must hold its operands until it sees in_rdy.
- out_rdy outside DONE has no effect.

Test Plan:
- (3+j4)/(1+j2), out_rdy=1 → out_vld exactly 25 cycles after accept; q_re=563 (2.199), q_im=−102 (−0.398), div_by_zero=0; in_rdy=1 one cycle after the handshake.
- (−128−j128)/(−128+j0) → q_re=256, q_im=256. Then (−128−j128)/(1+j0) → q_re=−32768, q_im=−32768.
- (5+j7)/(0+j0) → out_vld 1 cycle after accept, div_by_zero=1, q_re=q_im=0. The next normal op (2+j0)/(1+j0) gives q_re=512, q_im=0, div_by_zero=0.
- Backpressure: out_rdy=0 for 10 cycles after out_vld → outputs and out_vld held constant and in_rdy=0 throughout. Raising out_rdy gives a single handshake.
- in_vld held high continuously with changing operands → only the operands present when in_rdy=1 are accepted. Results match a software model, and no accepts occur closer than 27 cycles apart.
- Assert rst at DIV iteration 10 → out_vld, q_re, q_im and div_by_zero all 0 and in_rdy=1 immediately (asynchronously). After release no stale result appears, and a new op completes correctly.
